// File: rtl/bf16_pkg.sv
// Shared bfloat16 constants and field helpers for the multiply scheduler.
package bf16_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 7;
    localparam int BIAS  = 127;

    localparam logic [15:0]      QNAN    = 16'h7FC0;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

    function automatic logic f_sign(input logic [15:0] v);
        return v[15];
    endfunction

    function automatic logic [EXP_W-1:0] f_exp(input logic [15:0] v);
        return v[14:7];
    endfunction

    function automatic logic [MAN_W-1:0] f_man(input logic [15:0] v);
        return v[6:0];
    endfunction

endpackage

// File: rtl/bf16_mul_core.sv
// Combinational bf16 multiply: truncating, denormals flushed,
// saturates to Inf on overflow and flushes to zero on underflow.
module bf16_mul_core
    import bf16_pkg::*;
(
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    output logic [15:0] z_o,
    output logic        ovf_o,
    output logic        unf_o
);

    logic             sgn;
    logic [EXP_W-1:0] xe, ye;
    logic [MAN_W-1:0] xm, ym, mant;
    logic [15:0]      mx, my, prod;
    logic signed [9:0] e;
    logic x_inf, y_inf, x_zero, y_zero, x_nan, y_nan;
    logic unused_prod;

    assign sgn = f_sign(x_i) ^ f_sign(y_i);
    assign xe  = f_exp(x_i);
    assign ye  = f_exp(y_i);
    assign xm  = f_man(x_i);
    assign ym  = f_man(y_i);

    assign mx   = {8'd0, 1'b1, xm};
    assign my   = {8'd0, 1'b1, ym};
    assign prod = mx * my;
    assign mant = prod[15] ? prod[14:8] : prod[13:7];
    assign unused_prod = ^prod[6:0];

    // 10-bit signed keeps both overflow and underflow visible
    assign e = $signed({2'b00, xe}) + $signed({2'b00, ye})
             - $signed(BIAS[9:0]) + $signed({9'd0, prod[15]});

    assign x_inf  = (xe == EXP_MAX);
    assign y_inf  = (ye == EXP_MAX);
    assign x_zero = (xe == '0);
    assign y_zero = (ye == '0);
    assign x_nan  = x_inf && (xm != '0);
    assign y_nan  = y_inf && (ym != '0);

    always_comb begin
        z_o   = {sgn, e[7:0], mant};
        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (x_nan || y_nan) begin
            z_o = QNAN;
        end else if ((x_inf && y_zero) || (x_zero && y_inf)) begin
            z_o = QNAN;
        end else if (x_inf || y_inf) begin
            z_o = {sgn, EXP_MAX, 7'd0};
        end else if (x_zero || y_zero) begin
            z_o = {sgn, 15'd0};
        end else if (e >= 10'sd255) begin
            z_o   = {sgn, EXP_MAX, 7'd0};
            ovf_o = 1'b1;
        end else if (e <= 10'sd0) begin
            z_o   = {sgn, 15'd0};
            unf_o = 1'b1;
        end
    end

endmodule

// File: rtl/bf16_mul_sched.sv
// Two-requester round-robin front end for one shared bf16 multiplier,
// with a 2-stage pipeline and a single tagged, back-pressured result port.
module bf16_mul_sched
    import bf16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [15:0] a_x,
    input  logic [15:0] a_y,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [15:0] b_x,
    input  logic [15:0] b_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_tag,
    output logic [15:0] out_z,
    output logic        out_ovf,
    output logic        out_unf,
    output logic [15:0] done_cnt
);

    logic        s1_valid_q, s1_tag_q;
    logic [15:0] s1_x_q, s1_y_q;
    logic        last_b_q;
    logic        out_valid_q, out_tag_q, out_ovf_q, out_unf_q;
    logic [15:0] out_z_q, done_cnt_q, done_cnt_d;

    logic        s2_adv, accept, grant_a, grant_b;
    logic [15:0] core_z;
    logic        core_ovf, core_unf;

    assign s2_adv = !out_valid_q || out_ready;
    assign accept = !s1_valid_q || s2_adv;

    // on a tie the requester that did not win last time goes first
    assign grant_a = accept && a_valid && (!b_valid || last_b_q);
    assign grant_b = accept && b_valid && (!a_valid || !last_b_q);

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    assign done_cnt_d = done_cnt_q + 16'd1;

    bf16_mul_core u_core (
        .x_i   (s1_x_q),
        .y_i   (s1_y_q),
        .z_o   (core_z),
        .ovf_o (core_ovf),
        .unf_o (core_unf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_tag_q    <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            last_b_q    <= 1'b1;
            out_valid_q <= 1'b0;
            out_tag_q   <= 1'b0;
            out_z_q     <= '0;
            out_ovf_q   <= 1'b0;
            out_unf_q   <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            if (accept) begin
                s1_valid_q <= grant_a || grant_b;
            end
            if (grant_a) begin
                s1_tag_q <= 1'b0;
                s1_x_q   <= a_x;
                s1_y_q   <= a_y;
            end else if (grant_b) begin
                s1_tag_q <= 1'b1;
                s1_x_q   <= b_x;
                s1_y_q   <= b_y;
            end
            if (grant_a || grant_b) begin
                last_b_q <= grant_b;
            end
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_tag_q <= s1_tag_q;
                    out_z_q   <= core_z;
                    out_ovf_q <= core_ovf;
                    out_unf_q <= core_unf;
                end
            end
            if (out_valid_q && out_ready) begin
                done_cnt_q <= done_cnt_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;
    assign out_z     = out_z_q;
    assign out_ovf   = out_ovf_q;
    assign out_unf   = out_unf_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_bf16_mul_sched.sv
// Randomised and directed bench for bf16_mul_sched with an arithmetic
// reference model and an in-order result scoreboard.
module tb_bf16_mul_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_ready, b_ready;
    logic [15:0] a_x = '0, a_y = '0, b_x = '0, b_y = '0;
    logic        out_valid, out_tag, out_ovf, out_unf;
    logic        out_ready = 1'b1;
    logic [15:0] out_z, done_cnt;

    int n_chk = 0;
    int n_pass = 0;

    logic [18:0] exp_q[$];
    logic [15:0] exp_done = '0;
    logic        tb_last_b = 1'b1;
    logic        have_prev = 1'b0;
    logic        prev_stall = 1'b0;
    logic [18:0] prev_out = '0;

    always #5 clk = ~clk;

    bf16_mul_sched dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_x       (a_x),
        .a_y       (a_y),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_x       (b_x),
        .b_y       (b_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tag   (out_tag),
        .out_z     (out_z),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf),
        .done_cnt  (done_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Value-level model: returns {ovf, unf, z}
    function automatic logic [17:0] ref_mul(input logic [15:0] x,
                                            input logic [15:0] y);
        int  xe, ye, xm, ym, e, m;
        logic s;
        real v;
        s  = x[15] ^ y[15];
        xe = int'(x[14:7]);
        ye = int'(y[14:7]);
        xm = int'(x[6:0]);
        ym = int'(y[6:0]);
        if ((xe == 255 && xm != 0) || (ye == 255 && ym != 0))
            return {2'b00, 16'h7FC0};
        if ((xe == 255 && ye == 0) || (xe == 0 && ye == 255))
            return {2'b00, 16'h7FC0};
        if (xe == 255 || ye == 255)
            return {2'b00, s, 8'hFF, 7'd0};
        if (xe == 0 || ye == 0)
            return {2'b00, s, 15'd0};
        v = (1.0 + xm / 128.0) * (1.0 + ym / 128.0);
        e = xe + ye - 127;
        if (v >= 2.0) begin
            v = v / 2.0;
            e = e + 1;
        end
        if (e >= 255) return {2'b10, s, 8'hFF, 7'd0};
        if (e <= 0) return {2'b01, s, 15'd0};
        m = int'($floor((v - 1.0) * 128.0));
        return {2'b00, s, e[7:0], m[6:0]};
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom % 8)
            0: return r;
            1: return {r[15], 8'h00, r[6:0]};
            2: return {r[15], 8'hFF, 7'd0};
            3: return {r[15], 8'hFF, 7'(($urandom % 127) + 1)};
            4: return {r[15], 8'($urandom_range(200, 254)), r[6:0]};
            5: return {r[15], 8'($urandom_range(1, 50)), r[6:0]};
            default: return {r[15], 8'($urandom_range(100, 160)), r[6:0]};
        endcase
    endfunction

    // Scoreboard, arbitration and stall monitor
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_done  = '0;
            tb_last_b = 1'b1;
            have_prev = 1'b0;
        end else begin
            if (have_prev && prev_stall) begin
                chk("hold", {13'd0, out_valid, out_tag, out_ovf, out_unf, out_z},
                    {13'd0, 1'b1, prev_out});
            end
            chk("grant", {29'd0, a_ready & ~a_valid, b_ready & ~b_valid,
                          a_ready & b_ready}, 32'd0);
            if (a_valid && b_valid && (a_ready || b_ready))
                chk("rr", {31'd0, b_ready}, {31'd0, ~tb_last_b});
            if (a_valid && a_ready) begin
                exp_q.push_back({1'b0, ref_mul(a_x, a_y)});
                tb_last_b = 1'b0;
            end
            if (b_valid && b_ready) begin
                exp_q.push_back({1'b1, ref_mul(b_x, b_y)});
                tb_last_b = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious", 32'd1, 32'd0);
                end else begin
                    chk("out", {13'd0, out_tag, out_ovf, out_unf, out_z},
                        {13'd0, exp_q.pop_front()});
                end
                chk("done", {16'd0, done_cnt}, {16'd0, exp_done});
                exp_done = exp_done + 16'd1;
            end
            prev_stall = out_valid & ~out_ready;
            prev_out   = {out_tag, out_ovf, out_unf, out_z};
            have_prev  = 1'b1;
        end
    end

    task automatic send_a(input logic [15:0] x, input logic [15:0] y);
        int n;
        a_valid = 1'b1;
        a_x = x;
        a_y = y;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_ready && n < 50);
        if (!a_ready) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic run_one(input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] z, input logic ovf,
                           input logic unf);
        int n;
        send_a(x, y);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("dir", {13'd0, out_valid, out_tag, out_ovf, out_unf, out_z},
            {13'd0, 1'b1, 1'b0, ovf, unf, z});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc_a, acc_b;
        int n;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_state", {12'd0, out_valid, out_tag, out_ovf, out_unf, out_z},
            32'd0);
        chk("rst_cnt", {16'd0, done_cnt}, 32'd0);

        // both requesters every cycle: A first after reset, then alternating
        a_valid = 1'b1; a_x = 16'h4000; a_y = 16'h4040;
        b_valid = 1'b1; b_x = 16'hBFC0; b_y = 16'h3FC0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("alt", {30'd0, a_ready, b_ready},
                {30'd0, (i % 2) == 0, (i % 2) == 1});
            @(posedge clk);
            #1;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // single op latency: grant edge, then out_valid one edge later
        a_valid = 1'b1; a_x = 16'h3FC0; a_y = 16'h3FC0;
        @(negedge clk);
        chk("lat_rdy", {31'd0, a_ready}, 32'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        chk("lat_e1", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("lat_e2", {13'd0, out_valid, out_tag, out_ovf, out_unf, out_z},
            {13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4010});
        repeat (2) @(posedge clk);
        #1;

        run_one(16'h7F00, 16'h7F00, 16'h7F80, 1'b1, 1'b0);
        run_one(16'h0080, 16'h0080, 16'h0000, 1'b0, 1'b1);
        run_one(16'h0000, 16'h7F80, 16'h7FC0, 1'b0, 1'b0);
        run_one(16'hFF80, 16'h3F80, 16'hFF80, 1'b0, 1'b0);
        run_one(16'h7FC1, 16'h3F80, 16'h7FC0, 1'b0, 1'b0);

        // backpressure: stream from A with the consumer stalled
        out_ready = 1'b0;
        a_valid = 1'b1;
        a_x = 16'h3F80; a_y = 16'h4000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            acc_a = a_ready;
            if (i >= 2) chk("bp_rdy", {31'd0, a_ready}, 32'd0);
            @(posedge clk);
            #1;
            if (acc_a) a_x = a_x + 16'h0080;
        end
        out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_ready && n < 20);
        @(posedge clk);
        #1;
        a_valid = 1'b0;

        // randomised traffic with random backpressure
        acc_a = 1'b0;
        acc_b = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!a_valid || acc_a) begin
                a_valid = ($urandom % 4) != 0;
                a_x = rand_op();
                a_y = rand_op();
            end
            if (!b_valid || acc_b) begin
                b_valid = ($urandom % 4) != 0;
                b_x = rand_op();
                b_y = rand_op();
            end
            out_ready = ($urandom % 10) < 7;
            @(negedge clk);
            acc_a = a_valid & a_ready;
            acc_b = b_valid & b_ready;
            @(posedge clk);
            #1;
        end

        // reset with both stages full
        a_valid = 1'b1;
        b_valid = 1'b0;
        a_x = 16'h4000; a_y = 16'h4000;
        out_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            @(posedge clk);
            #1;
        end while ((a_ready || !out_valid) && n < 10);
        chk("full", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid", {15'd0, out_valid, done_cnt}, 32'd0);
        out_ready = 1'b1;
        b_valid = 1'b1;
        b_x = 16'h3F80; b_y = 16'h3F80;
        @(negedge clk);
        chk("rst_tie", {30'd0, a_ready, b_ready}, 32'd2);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;

        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
